// File: rtl/adder_eval_pkg.sv
// Shared definitions for the adder characterisation blocks.
//   ed_width  : width of an exact result / error distance for an N-bit adder
//   cnt_width : width of a counter that must reach WINDOW
//   mon_state_e : window-monitor FSM states
package adder_eval_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } mon_state_e;

   // N-bit operands plus carry-in need N+1 bits, so does the DUT's {cout, sum}
   function automatic int ed_width(input int n);
      return n + 1;
   endfunction

   function automatic int cnt_width(input int window);
      return $clog2(window + 1);
   endfunction

endpackage

// File: rtl/adder_error_distance.sv
// Combinational reference adder and error distance.
//   a, b, cin         : operands as driven to the adder under test
//   sum_dut, cout_dut : result returned by the adder under test
//   exact             : a + b + cin, full N+1 bits
//   ed                : |exact - {cout_dut, sum_dut}|, full N+1 bits
module adder_error_distance
   import adder_eval_pkg::*;
#(
   parameter int N = 8,
   localparam int EDW = ed_width(N)
) (
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic           cin,
   input  logic [N-1:0]   sum_dut,
   input  logic           cout_dut,
   output logic [EDW-1:0] exact,
   output logic [EDW-1:0] ed
);

   logic [EDW-1:0] dut;

   always_comb begin
      exact = {1'b0, a} + {1'b0, b} + EDW'(cin);
      dut   = {cout_dut, sum_dut};
      ed    = (exact >= dut) ? (exact - dut) : (dut - exact);
   end

endmodule

// File: rtl/adder_error_monitor.sv
// Response-side checker for adders under characterisation. Accepts one
// sample per cycle, recomputes the exact sum and accumulates error metrics
// over a window of WINDOW samples.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start, results of last window held
// RUN   | accepting samples until WINDOW have been taken
// DRAIN | no new samples, last accepted sample still in flight
// DONE  | results final, done high for this one cycle
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start               : clear metrics and open a new window (wins over in_valid)
//   in_valid / in_ready : sample handshake, accepted when both high
//   a, b, cin           : operands driven to the adder under test
//   sum_dut, cout_dut   : adder-under-test result
//   busy, done          : window open / draining, one-cycle completion pulse
//   sample_cnt, err_cnt : samples accumulated, samples with nonzero ED
//   ed_sum, ed_max      : sum and maximum of ED over the window
//   last_ed             : ED of the most recently accumulated sample
module adder_error_monitor
   import adder_eval_pkg::*;
#(
   parameter int N      = 8,
   parameter int WINDOW = 16,
   localparam int CNT_W = cnt_width(WINDOW),
   localparam int EDW   = ed_width(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         a,
   input  logic [N-1:0]         b,
   input  logic                 cin,
   input  logic [N-1:0]         sum_dut,
   input  logic                 cout_dut,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     sample_cnt,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [EDW+CNT_W-1:0] ed_sum,
   output logic [EDW-1:0]       ed_max,
   output logic [EDW-1:0]       last_ed
);

   localparam logic [CNT_W-1:0] WIN_C  = CNT_W'(WINDOW);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WINDOW - 1);

   mon_state_e           state_q;
   logic [CNT_W-1:0]     acc_cnt_q;
   logic                 s1_valid_q;
   logic [EDW-1:0]       s1_exact_q;
   logic [EDW-1:0]       s1_dut_q;
   logic [CNT_W-1:0]     sample_cnt_q;
   logic [CNT_W-1:0]     err_cnt_q;
   logic [EDW+CNT_W-1:0] ed_sum_q;
   logic [EDW-1:0]       ed_max_q;
   logic [EDW-1:0]       last_ed_q;

   logic [EDW-1:0]       s0_exact;
   logic [EDW-1:0]       s0_ed_unused;
   logic [EDW-1:0]       s2_ed;
   logic                 accept;

   // Stage 0 only needs the exact sum; the ED itself is formed in stage 2
   // from the registered pair so the subtractor sits after the adder flop.
   adder_error_distance #(
      .N (N)
   ) u_ed (
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sum_dut  (sum_dut),
      .cout_dut (cout_dut),
      .exact    (s0_exact),
      .ed       (s0_ed_unused)
   );

   always_comb begin
      // start forces in_ready low so a coincident sample is never taken
      in_ready = (state_q == RUN) && (acc_cnt_q < WIN_C) && !start;
      accept   = in_valid && in_ready;
      busy     = (state_q == RUN) || (state_q == DRAIN);
      done     = (state_q == DONE);
      s2_ed    = (s1_exact_q >= s1_dut_q) ? (s1_exact_q - s1_dut_q)
                                          : (s1_dut_q - s1_exact_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         acc_cnt_q    <= '0;
         s1_valid_q   <= 1'b0;
         s1_exact_q   <= '0;
         s1_dut_q     <= '0;
         sample_cnt_q <= '0;
         err_cnt_q    <= '0;
         ed_sum_q     <= '0;
         ed_max_q     <= '0;
         last_ed_q    <= '0;
      end else if (start) begin
         // Restart from any state: flush the pipeline and clear metrics
         state_q      <= RUN;
         acc_cnt_q    <= '0;
         s1_valid_q   <= 1'b0;
         sample_cnt_q <= '0;
         err_cnt_q    <= '0;
         ed_sum_q     <= '0;
         ed_max_q     <= '0;
         last_ed_q    <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_exact_q <= s0_exact;
            s1_dut_q   <= {cout_dut, sum_dut};
            acc_cnt_q  <= acc_cnt_q + CNT_W'(1);
         end

         if (s1_valid_q) begin
            sample_cnt_q <= sample_cnt_q + CNT_W'(1);
            if (s2_ed != '0) begin
               err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
            ed_sum_q  <= ed_sum_q + {{CNT_W{1'b0}}, s2_ed};
            if (s2_ed > ed_max_q) begin
               ed_max_q <= s2_ed;
            end
            last_ed_q <= s2_ed;
         end

         unique case (state_q)
            IDLE:  state_q <= IDLE;
            RUN: begin
               if (accept && (acc_cnt_q == LAST_C)) begin
                  state_q <= DRAIN;
               end
            end
            // Stage 1 empty now means stage 2 consumes nothing at this edge
            DRAIN: begin
               if (!s1_valid_q) begin
                  state_q <= DONE;
               end
            end
            DONE:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sample_cnt = sample_cnt_q;
   assign err_cnt    = err_cnt_q;
   assign ed_sum     = ed_sum_q;
   assign ed_max     = ed_max_q;
   assign last_ed    = last_ed_q;

endmodule
